// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, FSM states and port ids for the two-port ALU arbiter.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request and response channels, each with valid/ready handshaking.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic [OP_W-1:0]   req_op;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              rsp_lt;
   logic              rsp_gt;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gt
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gt
   );
endinterface

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor (unknown codes add), plus signed compare flags of A vs B.
module alu
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              lt,
   output logic              gt
);
   always_comb begin
      result = a + b;
      case (op)
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         default: result = a + b;
      endcase
   end

   assign zero = (result == '0);
   assign lt   = ($signed(a) < $signed(b));
   assign gt   = ($signed(a) > $signed(b));
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; combinational, on a tie favours the port not served last.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt_vld,
   output logic gnt_id
);
   assign gnt_vld = valid0 | valid1;
   assign gnt_id  = (valid0 && valid1) ? ~last_grant : ~valid0;
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two ports; response valid two cycles after accept.
// Response is held until the owner takes it; no new request is accepted meanwhile.
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     p0,
   alu_arbiter_if.slave     p1,
   output logic [CNT_W-1:0] op_count
);
   state_t            state, state_nxt;
   logic              last_grant, owner;
   logic              gnt_vld, gnt_id;
   logic              accept, rsp_hs;
   logic [DATA_W-1:0] a_q, b_q, res_q, alu_res;
   logic [OP_W-1:0]   op_q;
   logic              zero_q, lt_q, gt_q;
   logic              alu_zero, alu_lt, alu_gt;

   rr_arb2 u_arb (
      .valid0     (p0.req_valid),
      .valid1     (p1.req_valid),
      .last_grant (last_grant),
      .gnt_vld    (gnt_vld),
      .gnt_id     (gnt_id)
   );

   alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_res),
      .zero   (alu_zero),
      .lt     (alu_lt),
      .gt     (alu_gt)
   );

   // rst_n gating keeps ready low during reset even though state is still settling.
   assign accept = rst_n && (state == S_IDLE) && gnt_vld;
   assign rsp_hs = (state == S_RESP) && ((owner == P1) ? p1.rsp_ready : p0.rsp_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (rsp_hs) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      p0.req_ready = accept && (gnt_id == P0);
      p1.req_ready = accept && (gnt_id == P1);
      p0.rsp_valid = rst_n && (state == S_RESP) && (owner == P0);
      p1.rsp_valid = rst_n && (state == S_RESP) && (owner == P1);
   end

   assign p0.rsp_result = res_q;
   assign p0.rsp_zero   = zero_q;
   assign p0.rsp_lt     = lt_q;
   assign p0.rsp_gt     = gt_q;
   assign p1.rsp_result = res_q;
   assign p1.rsp_zero   = zero_q;
   assign p1.rsp_lt     = lt_q;
   assign p1.rsp_gt     = gt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= P1;
         owner      <= P0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         lt_q       <= 1'b0;
         gt_q       <= 1'b0;
         op_count   <= '0;
      end else begin
         if (accept) begin
            last_grant <= gnt_id;
            owner      <= gnt_id;
            a_q        <= (gnt_id == P1) ? p1.req_a  : p0.req_a;
            b_q        <= (gnt_id == P1) ? p1.req_b  : p0.req_b;
            op_q       <= (gnt_id == P1) ? p1.req_op : p0.req_op;
         end
         if (state == S_EXEC) begin
            res_q  <= alu_res;
            zero_q <= alu_zero;
            lt_q   <= alu_lt;
            gt_q   <= alu_gt;
         end
         if (rsp_hs) op_count <= op_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-port ops plus tie, backpressure, reset and wrap sequences.
module tb_alu_arbiter;
   import alu_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] op_count;
   logic [3:0] exp_cnt;
   int         total  = 0;
   int         passed = 0;

   alu_arbiter_if #(.DATA_W(32), .OP_W(4)) i0 ();
   alu_arbiter_if #(.DATA_W(32), .OP_W(4)) i1 ();

   alu_arbiter #(.DATA_W(32), .OP_W(4), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .p0       (i0),
      .p1       (i1),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
      logic        lt;
      logic        gt;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic rdy(input logic p);
      return p ? i1.req_ready : i0.req_ready;
   endfunction

   function automatic logic rvld(input logic p);
      return p ? i1.rsp_valid : i0.rsp_valid;
   endfunction

   function automatic logic [31:0] rres(input logic p);
      return p ? i1.rsp_result : i0.rsp_result;
   endfunction

   function automatic logic [2:0] rflg(input logic p);
      return p ? {i1.rsp_zero, i1.rsp_lt, i1.rsp_gt} : {i0.rsp_zero, i0.rsp_lt, i0.rsp_gt};
   endfunction

   task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op);
      if (p) begin
         i1.req_valid = v; i1.req_a = a; i1.req_b = b; i1.req_op = op;
      end else begin
         i0.req_valid = v; i0.req_a = a; i0.req_b = b; i0.req_op = op;
      end
   endtask

   task automatic set_rsp_rdy(input logic p, input logic v);
      if (p) i1.rsp_ready = v;
      else   i0.rsp_ready = v;
   endtask

   task automatic do_op(input vec_t v);
      @(posedge clk); #1;
      set_req(v.port, 1'b1, v.a, v.b, v.op);
      @(negedge clk);
      chk("accept_ready", rdy(v.port), 1);
      chk("other_ready", rdy(!v.port), 0);
      @(posedge clk); #1;
      set_req(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("exec_no_rsp", rvld(v.port), 0);
      @(posedge clk);
      @(negedge clk);
      chk("rsp_valid", rvld(v.port), 1);
      chk("rsp_other_valid", rvld(!v.port), 0);
      chk("result", rres(v.port), v.res);
      chk("flags", rflg(v.port), {v.z, v.lt, v.gt});
      set_rsp_rdy(v.port, 1'b1);
      @(posedge clk); #1;
      set_rsp_rdy(v.port, 1'b0);
      exp_cnt++;
      @(negedge clk);
      chk("op_count", op_count, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //          port a             b             op       res           z     lt    gt
      vecs[0]  = '{P0, 32'd5,        32'd3,        ALU_SUB, 32'd2,        1'b0, 1'b0, 1'b1};
      vecs[1]  = '{P1, 32'hFFFFFFFF, 32'd1,        ALU_ADD, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[2]  = '{P0, 32'h80000000, 32'h80000000, ALU_SUB, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[3]  = '{P1, 32'd2,        32'd2,        4'b0111, 32'd4,        1'b0, 1'b0, 1'b0};
      vecs[4]  = '{P0, 32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 32'h00F000F0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{P1, 32'h12340000, 32'h00005678, ALU_OR,  32'h12345678, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{P0, 32'hAAAAAAAA, 32'h55555555, ALU_XOR, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{P1, 32'h7FFFFFFF, 32'd1,        ALU_ADD, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{P0, 32'd0,        32'd0,        ALU_ADD, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[9]  = '{P1, 32'd1,        32'd2,        ALU_SUB, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{P0, 32'h10,       32'h3,        4'hF,    32'h13,       1'b0, 1'b0, 1'b1};

      rst_n = 1'b0;
      exp_cnt = 4'd0;
      set_req(P0, 1'b1, 32'd9, 32'd9, ALU_ADD);
      set_req(P1, 1'b1, 32'd9, 32'd9, ALU_ADD);
      i0.rsp_ready = 1'b0;
      i1.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req0_ready", i0.req_ready, 0);
      chk("reset_req1_ready", i1.req_ready, 0);
      chk("reset_rsp0_valid", i0.rsp_valid, 0);
      chk("reset_rsp1_valid", i1.rsp_valid, 0);
      chk("reset_op_count", op_count, 0);
      chk("reset_result", i0.rsp_result, 0);
      chk("reset_flags", rflg(P0), 0);
      set_req(P0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(P1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) do_op(vecs[i]);

      // Reset while in EXEC: the operation must vanish and arbitration restart.
      @(posedge clk); #1;
      set_req(P0, 1'b1, 32'd7, 32'd7, ALU_ADD);
      @(negedge clk);
      chk("rst_exec_accept", i0.req_ready, 1);
      @(posedge clk); #1;
      set_req(P0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt = 4'd0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_exec_rsp0", i0.rsp_valid, 0);
         chk("rst_exec_rsp1", i1.rsp_valid, 0);
      end
      chk("rst_exec_count", op_count, 0);
      chk("rst_exec_result", i0.rsp_result, 0);

      // Tie: port 0 first, port 1 waits for IDLE.
      @(posedge clk); #1;
      set_req(P0, 1'b1, 32'd1, 32'd2, ALU_ADD);
      set_req(P1, 1'b1, 32'hFF, 32'h0F, ALU_XOR);
      @(negedge clk);
      chk("tie_ready0", i0.req_ready, 1);
      chk("tie_ready1", i1.req_ready, 0);
      @(posedge clk); #1;
      set_req(P0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("tie_exec_ready1", i1.req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("tie_rsp0_valid", i0.rsp_valid, 1);
      chk("tie_rsp0_result", i0.rsp_result, 32'd3);
      chk("tie_resp_ready1", i1.req_ready, 0);
      i0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      i0.rsp_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk("tie_ready1_idle", i1.req_ready, 1);
      chk("tie_count1", op_count, exp_cnt);
      @(posedge clk); #1;
      set_req(P1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      chk("tie_rsp1_valid", i1.rsp_valid, 1);
      chk("tie_rsp1_result", i1.rsp_result, 32'hF0);
      chk("tie_rsp1_flags", rflg(P1), 3'b001);

      // Backpressure on port 1 with a pending port 0 request and a stray rsp0_ready.
      set_req(P0, 1'b1, 32'hFF, 32'h0F, ALU_AND);
      i0.rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_rsp1_valid", i1.rsp_valid, 1);
         chk("bp_rsp1_result", i1.rsp_result, 32'hF0);
         chk("bp_ready0", i0.req_ready, 0);
         chk("bp_ready1", i1.req_ready, 0);
         chk("bp_rsp0_valid", i0.rsp_valid, 0);
      end
      chk("bp_count", op_count, exp_cnt);
      i0.rsp_ready = 1'b0;
      i1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      i1.rsp_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk("bp_after_ready0", i0.req_ready, 1);
      chk("bp_after_rsp1", i1.rsp_valid, 0);
      chk("bp_after_count", op_count, exp_cnt);
      @(posedge clk); #1;
      set_req(P0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp0_valid_final", i0.rsp_valid, 1);
      chk("bp_rsp0_result", i0.rsp_result, 32'h0F);
      chk("bp_rsp0_flags", rflg(P0), 3'b001);
      i0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      i0.rsp_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk("bp_final_count", op_count, exp_cnt);

      // 3 done since reset; 14 more makes 17, wrapping the 4-bit counter to 1.
      for (int i = 0; i < 14; i++) do_op(vecs[i % 11]);
      chk("wrap_count", op_count, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit ALU datapath between two requesters: port 0 is the main datapath, port 1 is an auxiliary unit such as a branch or address helper.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands and results are registered, and responses carry the result plus zero/lt/gt flags.
- Sits between the control/decode logic and the ALU instance in the multi-cycle core variant.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, ALU operation code width
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
- req0_a  in  DATA_W  port 0 operand A
- req0_b  in  DATA_W  port 0 operand B
- req0_op  in  OP_W  port 0 operation
- rsp0_valid  out  1  port 0 response valid
- rsp0_ready  in  1  port 0 consumer ready
- rsp0_result  out  DATA_W  port 0 result
- rsp0_zero / rsp0_lt / rsp0_gt  out  1 each  port 0 flags
- req1_* / rsp1_*  same set, for port 1
- op_count  out  CNT_W  count of completed (response-handshaked) operations

Behaviour:
- Op encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR. Any other code executes ADD.
- Arithmetic wraps modulo 2^DATA_W. No overflow flag.
- zero = (result == 0).
- lt/gt are a signed two's-complement compare of A vs B.
  - A == B gives lt=0, gt=0.
  - lt and gt are never both 1.
  - Flags depend only on A and B, not on op.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: a request handshake (reqX_valid & reqX_ready) latches A, B, op and the owner id; next state EXEC.
  - EXEC: one cycle. The ALU evaluates the latched operands; result and flags are registered into the response register. Next state RESP.
  - RESP: rspX_valid=1 for the owner only. Hold result/flags stable until rspX_ready=1. On that handshake: next state IDLE, op_count += 1.
- Latency: request accepted in cycle N; rsp valid from cycle N+2. Minimum 3 cycles per operation.
- Ready rules:
  - reqX_ready is high only in IDLE and only for the granted port.
  - Readiness may depend on valids; requesters must not make valid depend on ready.
  - Once asserted, a requester holds valid and its operands until the handshake.
- Arbitration in IDLE:
  - One port valid: that port is granted.
  - Both valid: the port not served last is granted.
  - last_grant updates on each request handshake.
- Other-port behaviour: while FSM is not IDLE, both req_ready=0. The non-owner's rsp_valid is always 0.
- Response ready asserted early: rsp_ready while rsp_valid=0 has no effect.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - Operand, result and flag registers = 0. op_count = 0.
  - All rsp_valid = 0 and all req_ready = 0 during reset.
  - An in-flight operation is discarded with no response.
- Port outputs: rsp_result/flags are visible on both ports' buses; only the owner's rsp_valid qualifies them.

Decomposition:
- Package alu_ctrl_pkg holds:
  - op-code constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR;
  - state encodings S_IDLE, S_EXEC, S_RESP;
  - port id constants P0, P1.
- Reuse the existing ALU module as the datapath instance.
- One new sub-module, rr_arb2: combinational two-input round-robin grant from valids plus the last_grant register.

Test Plan:
- Port 0 only: A=5, B=3, op SUB.
  - Expect req0_ready high in the accept cycle; rsp0_valid two cycles later with result=2, zero=0, lt=0, gt=1.
  - op_count=1 after the response handshake.
- Both ports valid from reset, same cycle: port 0 ADD 1+2, port 1 XOR 0xFF^0x0F.
  - Expect port 0 served first with result 3.
  - Then port 1 with 0xF0; its req1_ready is not asserted until FSM returns to IDLE.
- Backpressure: rsp1_ready held low for 5 cycles in RESP.
  - Expect rsp1_valid and result stable throughout, req0/req1_ready=0, and no new accept until the response handshake.
- Signed flags:
  - A=0xFFFFFFFF, B=1: expect lt=1, gt=0.
  - A=B=0x80000000, op SUB: expect result 0, zero=1, lt=0, gt=0.
  - Op 0111 with A=2, B=2: expect result 4.
- Reset in EXEC: assert rst_n=0 for one edge after accept.
  - Expect no rsp_valid afterwards, op_count=0, and the next tie granted to port 0.
- Counter wrap: with CNT_W=4, complete 17 operations; expect op_count=1.
